// File: rtl/image_write_sequencer.sv
// image_write_sequencer
//   Packs a stream of RGB pixels from the processing core into two-pixel
//   beats for the BMP image writer. Each beat is offered with out_valid and
//   fires as a one-cycle hsync strobe when the writer is ready. The block
//   tracks the column/row position of the next beat and pulses frame_done
//   once the last beat of the frame has fired.
//
// Ports
//   clk, Reset           clock (posedge), asynchronous active-high reset
//   start                begin a frame (only honoured while idle)
//   pix_valid/pix_ready  input pixel handshake, pixel on pix_r/pix_g/pix_b
//   sink_ready           writer can take a beat this cycle
//   hsync                beat strobe (out_valid & sink_ready)
//   R0/G0/B0, R1/G1/B1   even-column / odd-column pixel of the current beat
//   col_beat, row        position of the next beat to fire
//   busy                 high whenever a frame is in progress
//   frame_done           one-cycle pulse after the frame's last beat fired
module image_write_sequencer #(
  parameter int Im_width  = 768,
  parameter int Im_height = 512,
  localparam int BEATS_PER_ROW = Im_width / 2,
  localparam int CW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1,
  localparam int RW = (Im_height > 1) ? $clog2(Im_height) : 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [7:0]    pix_r,
  input  logic [7:0]    pix_g,
  input  logic [7:0]    pix_b,
  input  logic          sink_ready,
  output logic          hsync,
  output logic [7:0]    R0,
  output logic [7:0]    G0,
  output logic [7:0]    B0,
  output logic [7:0]    R1,
  output logic [7:0]    G1,
  output logic [7:0]    B1,
  output logic [CW-1:0] col_beat,
  output logic [RW-1:0] row,
  output logic          busy,
  output logic          frame_done
);

  localparam int TOTAL_BEATS = BEATS_PER_ROW * Im_height;
  localparam int BW = $clog2(TOTAL_BEATS + 1);

  typedef enum logic [1:0] {IDLE, PIX0, PIX1, DONE} state_t;

  state_t        state_q, state_d;
  logic [23:0]   even_q, even_d;
  logic [47:0]   beat_q, beat_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] loaded_q, loaded_d;
  logic          odd_ok;

  always_comb begin
    state_d     = state_q;
    even_d      = even_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    col_d       = col_q;
    row_d       = row_q;
    loaded_d    = loaded_q;
    pix_ready   = 1'b0;
    frame_done  = 1'b0;
    hsync       = out_valid_q & sink_ready;
    // The odd pixel may only be taken if the beat register is free or is
    // being emptied this very cycle.
    odd_ok      = !out_valid_q || sink_ready;

    // Position counters follow fired beats, not loaded beats.
    if (hsync) begin
      out_valid_d = 1'b0;
      if (col_q == CW'(BEATS_PER_ROW - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(Im_height - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PIX0;
          col_d    = '0;
          row_d    = '0;
          loaded_d = '0;
        end
      end
      PIX0: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          even_d  = {pix_r, pix_g, pix_b};
          state_d = PIX1;
        end
      end
      PIX1: begin
        pix_ready = odd_ok;
        if (pix_valid && odd_ok) begin
          // A reload overrides the hsync clear above: no bubble between beats.
          beat_d      = {even_q, pix_r, pix_g, pix_b};
          out_valid_d = 1'b1;
          loaded_d    = loaded_q + 1'b1;
          // End of frame is decided by beats loaded so it does not depend on
          // when the writer drains them.
          state_d     = (loaded_q == BW'(TOTAL_BEATS - 1)) ? DONE : PIX0;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      loaded_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      col_q       <= col_d;
      row_q       <= row_d;
      loaded_q    <= loaded_d;
    end
  end

  // The even-pixel holding register is pure data; its content is only
  // consumed after being written in PIX0.
  always_ff @(posedge clk) begin
    even_q <= even_d;
  end

  assign {R0, G0, B0, R1, G1, B1} = beat_q;
  assign col_beat = col_q;
  assign row      = row_q;
  assign busy     = (state_q != IDLE);

endmodule
